// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants, types and helpers for the multi-read-port register file.
//   - DEF_WIDTH / DEF_DEPTH / DEF_NUM_RD : default parameter values
//   - ZERO_REG : index of the hardwired-zero register (x0)
//   - data_t / addr_t : data and register-address vectors at default sizes
//   - even_parity() : parity helper used when REGFILE_PARITY_EN is defined
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_REG   = 0;

  typedef logic [DEF_WIDTH-1:0]         data_t;
  typedef logic [$clog2(DEF_DEPTH)-1:0] addr_t;

  // Even-parity bit: set so that data plus parity has an even number of ones.
  // Callers zero-extend their data to 64 bits, so WIDTH must not exceed 64
  // when parity is enabled.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
//   One registered read port of regfile_mp. Masks x0 to zero, forwards a
//   same-cycle writeback to the same register, and registers the read data,
//   the post-update busy bit and (with REGFILE_PARITY_EN) a parity error flag.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   rd_addr               register address sampled this cycle
//   wr_en/wr_addr/wr_data writeback bus, used for the bypass compare
//   arr_data              array contents at rd_addr (combinational)
//   busy_next             next-state busy bit of rd_addr
//   arr_parity            stored parity bit at rd_addr   (REGFILE_PARITY_EN)
//   parity_err            registered parity mismatch     (REGFILE_PARITY_EN)
//   rd_data, rd_busy      registered outputs, 1-cycle latency
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] arr_data,
  input  logic             busy_next,
`ifdef REGFILE_PARITY_EN
  input  logic             arr_parity,
  output logic             parity_err,
`endif
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_busy
);

  logic             is_zero;
  logic             bypass;
  logic [WIDTH-1:0] data_next;

  assign is_zero   = (rd_addr == AW'(ZERO_REG));
  assign bypass    = wr_en && (wr_addr == rd_addr) && !is_zero;
  assign data_next = is_zero ? '0 : (bypass ? wr_data : arr_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else begin
      rd_data <= data_next;
      rd_busy <= busy_next;
    end
  end

`ifdef REGFILE_PARITY_EN
  // Forwarded data never went through storage, so it cannot be corrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= !is_zero && !bypass &&
                    (even_parity(64'(arr_data)) != arr_parity);
    end
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised integer register file with NUM_RD registered read ports,
//   x0 hardwired to zero, write-to-read bypass and a per-register busy
//   scoreboard (set on issue, cleared on writeback, cleared by flush).
//   Optional macro REGFILE_PARITY_EN adds per-register even parity with an
//   error-injection input and per-port parity error outputs.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   rd_addr[NUM_RD]      read addresses; rd_data/rd_busy follow one cycle later
//   rd_data[NUM_RD]      registered read data (bypassed from writeback)
//   rd_busy[NUM_RD]      registered post-update busy bit of each read address
//   wr_en/wr_addr/wr_data writeback
//   issue_en/issue_addr  mark destination register busy
//   flush                clear the whole scoreboard
//   busy_vec[DEPTH]      registered scoreboard, bit 0 always 0
//   inj_parity_flip      store inverted parity with this write (parity only)
//   rd_parity_err[NUM_RD] registered parity mismatch per port (parity only)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NUM_RD = DEF_NUM_RD,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_addr,
  input  logic                         flush,
  output logic [DEPTH-1:0]             busy_vec
`ifdef REGFILE_PARITY_EN
  ,
  input  logic                         inj_parity_flip,
  output logic [NUM_RD-1:0]            rd_parity_err
`endif
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic             wr_ok;

  assign wr_ok = wr_en && (wr_addr != AW'(ZERO_REG));

  // Register array; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem_reg[r] <= '0;
    end else if (wr_ok) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0] par_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_reg <= '0;
    end else if (wr_ok) begin
      par_reg[wr_addr] <= even_parity(64'(wr_data)) ^ inj_parity_flip;
    end
  end
`endif

  // Scoreboard next state. Issue beats a same-cycle writeback to the same
  // register because the issuing instruction is the newer producer.
  always_comb begin
    busy_next = busy_reg;
    if (flush) begin
      busy_next = '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (issue_en && (issue_addr == AW'(r))) begin
          busy_next[r] = 1'b1;
        end else if (wr_en && (wr_addr == AW'(r))) begin
          busy_next[r] = 1'b0;
        end
      end
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  assign busy_vec = busy_reg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    regfile_read_port #(
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_port (
      .clk        (clk),
      .reset      (reset),
      .rd_addr    (rd_addr[gi]),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .arr_data   (mem_reg[rd_addr[gi]]),
      .busy_next  (busy_next[rd_addr[gi]]),
`ifdef REGFILE_PARITY_EN
      .arr_parity (par_reg[rd_addr[gi]]),
      .parity_err (rd_parity_err[gi]),
`endif
      .rd_data    (rd_data[gi]),
      .rd_busy    (rd_busy[gi])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Scoreboard bench for regfile_mp (default parameters, 2 read ports).
//   Stimulus pushes expected responses tagged with the cycle they appear;
//   a monitor pops and compares them shortly after each rising edge.
//   Define REGFILE_PARITY_EN to also exercise the parity feature.
module tb_regfile_mp;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_busy;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             issue_en;
  logic [4:0]       issue_addr;
  logic             flush;
  logic [31:0]      busy_vec;
`ifdef REGFILE_PARITY_EN
  logic             inj_parity_flip;
  logic [1:0]       rd_parity_err;
`endif

  regfile_mp dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
`ifdef REGFILE_PARITY_EN
    ,
    .inj_parity_flip (inj_parity_flip),
    .rd_parity_err   (rd_parity_err)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_VEC  = 2;
  localparam int K_PERR = 3;

  typedef struct {
    int          kind;
    int          port;
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  function automatic string kname(int k);
    case (k)
      K_DATA:  return "rd_data";
      K_BUSY:  return "rd_busy";
      K_VEC:   return "busy_vec";
      default: return "rd_parity_err";
    endcase
  endfunction

  // Monitor: every edge, compare all expectations due at this edge.
  exp_t        e;
  logic [31:0] act;
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      case (e.kind)
        K_DATA:  act = rd_data[e.port];
        K_BUSY:  act = 32'(rd_busy[e.port]);
        K_VEC:   act = busy_vec;
`ifdef REGFILE_PARITY_EN
        K_PERR:  act = 32'(rd_parity_err[e.port]);
`endif
        default: act = 32'hFFFF_FFFF;
      endcase
      checks = checks + 1;
      if (act !== e.val) begin
        failures = failures + 1;
        $display("FAIL %s[%0d] cycle %0d: got %h expected %h",
                 kname(e.kind), e.port, cyc, act, e.val);
      end else begin
        $display("ok   %s[%0d] cycle %0d: %h", kname(e.kind), e.port, cyc, act);
      end
    end
  end

  function automatic void expect_v(int kind, int port, logic [31:0] v);
    exp_t n;
    n.kind = kind;
    n.port = port;
    n.due  = cyc + 1;
    n.val  = v;
    q.push_back(n);
  endfunction

  task automatic idle();
    reset      = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    flush      = 1'b0;
`ifdef REGFILE_PARITY_EN
    inj_parity_flip = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic iss(input logic [4:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr[0] = a0;
    rd_addr[1] = a1;
  endtask

  initial begin
    // Reset with a write and issue pending: both must be discarded.
    idle(); reset = 1'b1; wr(5'd2, 32'h2222); iss(5'd2); rd(5'd2, 5'd2);
    expect_v(K_DATA, 0, 0); expect_v(K_DATA, 1, 0);
    expect_v(K_BUSY, 0, 0); expect_v(K_BUSY, 1, 0);
    expect_v(K_VEC, 0, 0);
`ifdef REGFILE_PARITY_EN
    expect_v(K_PERR, 0, 0); expect_v(K_PERR, 1, 0);
`endif
    tick();

    // Every register reads zero after reset.
    for (int i = 1; i < 32; i++) begin
      idle(); rd(5'(i), 5'(32 - i));
      expect_v(K_DATA, 0, 0); expect_v(K_DATA, 1, 0);
      expect_v(K_BUSY, 0, 0); expect_v(K_BUSY, 1, 0);
      if (i == 31) expect_v(K_VEC, 0, 0);
      tick();
    end

    // Write x5, then read it back on port 0 with x0 on port 1.
    idle(); wr(5'd5, 32'hDEADBEEF);
    expect_v(K_DATA, 0, 0); expect_v(K_DATA, 1, 0);
    tick();
    idle(); rd(5'd5, 5'd0);
    expect_v(K_DATA, 0, 32'hDEADBEEF); expect_v(K_DATA, 1, 0);
    tick();

    // Writes to x0 are ignored and never bypassed.
    idle(); wr(5'd0, 32'h1234); rd(5'd0, 5'd0);
    expect_v(K_DATA, 0, 0); expect_v(K_DATA, 1, 0);
    tick();
    idle(); rd(5'd0, 5'd0);
    expect_v(K_DATA, 0, 0); expect_v(K_DATA, 1, 0);
    tick();

    // Bypass on both ports with identical addresses, then array read.
    idle(); wr(5'd7, 32'hA5A5A5A5); rd(5'd7, 5'd7);
    expect_v(K_DATA, 0, 32'hA5A5A5A5); expect_v(K_DATA, 1, 32'hA5A5A5A5);
    tick();
    idle(); rd(5'd7, 5'd5);
    expect_v(K_DATA, 0, 32'hA5A5A5A5); expect_v(K_DATA, 1, 32'hDEADBEEF);
    tick();

    // Scoreboard: issue x3.
    idle(); iss(5'd3); rd(5'd3, 5'd0);
    expect_v(K_DATA, 0, 0); expect_v(K_BUSY, 0, 1); expect_v(K_BUSY, 1, 0);
    expect_v(K_VEC, 0, 32'h8);
    tick();
    // Writeback x3 plus re-issue x3: stays busy, data bypassed.
    idle(); wr(5'd3, 32'h33); iss(5'd3); rd(5'd3, 5'd0);
    expect_v(K_DATA, 0, 32'h33); expect_v(K_BUSY, 0, 1);
    expect_v(K_VEC, 0, 32'h8);
    tick();
    // Writeback x3 alone: busy clears.
    idle(); wr(5'd3, 32'h44); rd(5'd3, 5'd0);
    expect_v(K_DATA, 0, 32'h44); expect_v(K_BUSY, 0, 0);
    expect_v(K_VEC, 0, 0);
    tick();
    // Issue x4.
    idle(); iss(5'd4); rd(5'd0, 5'd4);
    expect_v(K_BUSY, 1, 1); expect_v(K_VEC, 0, 32'h10);
    tick();
    // Flush beats a same-cycle issue; the write still lands.
    idle(); flush = 1'b1; wr(5'd6, 32'h66); iss(5'd8); rd(5'd4, 5'd8);
    expect_v(K_BUSY, 0, 0); expect_v(K_BUSY, 1, 0); expect_v(K_VEC, 0, 0);
    tick();
    // Issue to x0 is ignored; flushed write is visible.
    idle(); iss(5'd0); rd(5'd6, 5'd0);
    expect_v(K_DATA, 0, 32'h66); expect_v(K_DATA, 1, 0);
    expect_v(K_BUSY, 1, 0); expect_v(K_VEC, 0, 0);
    tick();

    // Mid-operation reset discards everything.
    idle(); iss(5'd9); rd(5'd9, 5'd5);
    expect_v(K_BUSY, 0, 1); expect_v(K_DATA, 1, 32'hDEADBEEF);
    expect_v(K_VEC, 0, 32'h200);
    tick();
    idle(); reset = 1'b1; iss(5'd10); wr(5'd10, 32'h10); rd(5'd5, 5'd10);
    expect_v(K_DATA, 0, 0); expect_v(K_DATA, 1, 0);
    expect_v(K_BUSY, 0, 0); expect_v(K_BUSY, 1, 0); expect_v(K_VEC, 0, 0);
    tick();
    idle(); rd(5'd5, 5'd10);
    expect_v(K_DATA, 0, 0); expect_v(K_DATA, 1, 0);
    expect_v(K_BUSY, 1, 0); expect_v(K_VEC, 0, 0);
    tick();

`ifdef REGFILE_PARITY_EN
    // Corrupt write of x9: bypassed read is clean, array read flags.
    idle(); wr(5'd9, 32'h1); inj_parity_flip = 1'b1; rd(5'd9, 5'd0);
    expect_v(K_DATA, 0, 32'h1); expect_v(K_PERR, 0, 0); expect_v(K_PERR, 1, 0);
    tick();
    idle(); rd(5'd9, 5'd0);
    expect_v(K_DATA, 0, 32'h1); expect_v(K_PERR, 0, 1); expect_v(K_PERR, 1, 0);
    tick();
    idle(); wr(5'd9, 32'h1);
    expect_v(K_PERR, 0, 0);
    tick();
    idle(); rd(5'd9, 5'd9);
    expect_v(K_DATA, 0, 32'h1); expect_v(K_PERR, 0, 0); expect_v(K_PERR, 1, 0);
    tick();
`endif

    idle();
    tick(); tick(); tick();
    checks = checks + 1;
    if (q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL pending_expectations: got %0d left expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RISC-V core. It replaces the single-read-pair register file.
- Adds a configurable read-port count, x0 hardwired to zero, and write-to-read bypass.
- Adds a per-register busy scoreboard: set on issue, cleared on writeback. The decode stage uses it for hazard detection.
- Sits between decode (read/issue) and writeback (write).

Parameters:
- WIDTH, 32, data width of each register in bits.
- DEPTH, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of independent read ports, 1 to 4.
- AW, $clog2(DEPTH), register-address width; derived, not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD x AW  read address for each port.
- rd_data  out  NUM_RD x WIDTH  registered read data; 1-cycle latency.
- rd_busy  out  NUM_RD  registered busy status of the addressed register.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback address.
- wr_data  in  WIDTH  writeback data.
- issue_en  in  1  mark the destination register busy.
- issue_addr  in  AW  destination register being issued.
- flush  in  1  clear all busy bits (pipeline flush).
- busy_vec  out  DEPTH  current scoreboard state; bit 0 is always 0.

Behaviour:
- Interface: reset is reset, synchronous, active-high; the clock is clk. All state updates on the rising clk edge.
- Reset:
  - All DEPTH registers are cleared to 0.
  - busy_vec is 0.
  - rd_data is all 0.
  - rd_busy is all 0.
  - Reset overrides wr_en, issue_en and flush in the same cycle.
  - Asserting reset mid-operation discards any in-flight write or issue.
- Write: when wr_en=1 and wr_addr!=0, the register at wr_addr takes wr_data at the edge. Writes to address 0 are ignored.
- Read:
  - Each port p samples rd_addr[p] at edge N. rd_data[p] shows the data after edge N, i.e. 1-cycle latency.
  - rd_addr[p]=0 returns 0.
- Bypass: if wr_en=1, wr_addr==rd_addr[p] and the address is nonzero in the same cycle, rd_data[p] takes wr_data, not the stale array value.
- Port independence: all NUM_RD ports operate independently. Identical addresses on several ports return identical data.
- Scoreboard next-state, per register r, evaluated in this priority order:
  - flush=1: busy[r] becomes 0 for all r. wr_en still writes data.
  - Otherwise, issue_en=1 and issue_addr==r (r!=0): busy[r] becomes 1. Issue wins over a same-cycle writeback to the same r, because it is a new producer.
  - Otherwise, wr_en=1 and wr_addr==r: busy[r] becomes 0.
  - Otherwise busy[r] is held.
  - issue_addr=0 is ignored.
- rd_busy: rd_busy[p] is registered and equals the next-state busy bit of rd_addr[p], i.e. after this cycle's issue/writeback/flush. This keeps it consistent with the bypassed rd_data.
- busy_vec is the registered scoreboard; it carries no bypass.
- Writeback to a non-busy register is legal: data is written and busy stays 0.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores one even-parity bit, computed from wr_data on write.
  - Adds input inj_parity_flip (1 bit). When asserted with a write, it stores the inverted parity.
  - Adds output rd_parity_err (NUM_RD bits), registered alongside rd_data. rd_parity_err[p]=1 when the stored parity mismatches the stored data of the read register.
  - Bypassed reads and reads of address 0 never flag an error.
  - Reset clears all parity bits to 0, which is consistent with zero data.
- Undefined: no parity storage and none of these ports; behaviour is otherwise identical.

Decomposition:
- Package regfile_pkg holds:
  - default WIDTH/DEPTH/NUM_RD constants.
  - ZERO_REG constant (0).
  - a typedef for register-address and data vectors.
  - a parity function used under REGFILE_PARITY_EN.
- One sub-module, regfile_read_port: address-0 masking, bypass compare, output register for rd_data, rd_busy and parity error. It is instantiated NUM_RD times via generate.

Test Plan:
- Reset: assert reset 1 cycle, then read x1..x31 -> rd_data=0 for each, busy_vec=0, rd_busy=0.
- Write x5=0xDEADBEEF; next cycle read port0=x5, port1=x0 -> port0 gives 0xDEADBEEF one cycle later; port1 gives 0.
- Write to x0: wr_en=1, wr_addr=0, wr_data=0x1234, then read x0 -> 0.
- Bypass: same cycle wr_en x7=0xA5A5A5A5 and rd_addr[0]=x7 (x7 was 0) -> rd_data[0]=0xA5A5A5A5 on the next cycle.
- Scoreboard:
  - issue x3 -> busy_vec[3]=1.
  - Next cycle, writeback x3 plus issue x3 -> busy stays 1.
  - Then writeback x3 alone -> busy 0.
  - issue x4, then flush -> busy_vec=0.
- Parity (macro defined): write x9=0x1 with inj_parity_flip=1, then read x9 -> rd_parity_err[0]=1. Rewrite x9 cleanly, then read -> rd_parity_err[0]=0.
